// File: rtl/block_emitter_pkg.sv
// block_emitter shared definitions: command codes, FSM states,
// token identifiers and the ASCII characters the emitter produces.
package block_emitter_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_BEGIN = 2'b01,
        OP_END   = 2'b10,
        OP_CLOSE = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_EMIT_BEGIN = 3'd1,
        S_EMIT_END   = 3'd2,
        S_EMIT_SP    = 3'd3,
        S_FLUSH      = 3'd4
    } state_e;

    // TOK_ENDSP is the full "end " token used while flushing
    typedef enum logic [1:0] {
        TOK_BEGIN = 2'd0,
        TOK_END   = 2'd1,
        TOK_SP    = 2'd2,
        TOK_ENDSP = 2'd3
    } tok_e;

    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_NUL   = 8'h00;
    localparam logic [7:0] CASE_BIT = 8'h20;

    function automatic logic [7:0] fold_case(
        input logic [7:0] c,
        input logic       upper
    );
        if (upper && c >= 8'h61 && c <= 8'h7A)
            return c & ~CASE_BIT;
        return c;
    endfunction

    function automatic tok_e state_token(input state_e s);
        tok_e t;
        case (s)
            S_EMIT_BEGIN: t = TOK_BEGIN;
            S_EMIT_END:   t = TOK_END;
            S_FLUSH:      t = TOK_ENDSP;
            default:      t = TOK_SP;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/block_token_rom.sv
// block_token_rom: maps (token, character index, case) to the
// character to emit and whether it is the token's last character.
module block_token_rom
    import block_emitter_pkg::*;
(
    input  tok_e       tok_i,
    input  logic [2:0] idx_i,
    input  logic       upper_i,
    output logic [7:0] char_o,
    output logic       last_o
);

    logic [7:0] ch;

    // character table; out-of-range indices end the token safely
    always_comb begin
        ch     = CH_NUL;
        last_o = 1'b0;
        unique case (tok_i)
            TOK_BEGIN: begin
                case (idx_i)
                    3'd0: ch = CH_B;
                    3'd1: ch = CH_E;
                    3'd2: ch = CH_G;
                    3'd3: ch = CH_I;
                    3'd4: begin ch = CH_N; last_o = 1'b1; end
                    default: last_o = 1'b1;
                endcase
            end
            TOK_END: begin
                case (idx_i)
                    3'd0: ch = CH_E;
                    3'd1: ch = CH_N;
                    3'd2: begin ch = CH_D; last_o = 1'b1; end
                    default: last_o = 1'b1;
                endcase
            end
            TOK_SP: begin
                ch     = CH_SP;
                last_o = 1'b1;
            end
            TOK_ENDSP: begin
                case (idx_i)
                    3'd0: ch = CH_E;
                    3'd1: ch = CH_N;
                    3'd2: ch = CH_D;
                    3'd3: begin ch = CH_SP; last_o = 1'b1; end
                    default: last_o = 1'b1;
                endcase
            end
        endcase
    end

    assign char_o = fold_case(ch, upper_i);

endmodule

// File: rtl/block_emitter.sv
// block_emitter: emits "begin "/"end " text tokens while tracking nesting.
// Define BLOCK_EMITTER_UPPER_EN to emit the token letters in uppercase.
module block_emitter
    import block_emitter_pkg::*;
#(
    parameter int MAX_DEPTH = 15,
    parameter int DEPTH_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    output logic               cmd_ready,
    output logic [7:0]         out,
    output logic               out_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               err
);

`ifdef BLOCK_EMITTER_UPPER_EN
    localparam logic UPPER = 1'b1;
`else
    localparam logic UPPER = 1'b0;
`endif

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
    localparam logic [DEPTH_W-1:0] ONE   = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] ZERO  = '0;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               last_q;
    logic [7:0]         out_q;
    logic               valid_q;
    logic [7:0]         rom_char;
    logic               rom_last;

    // next position in the character stream and command handling
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        depth_d = depth_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                idx_d = 3'd0;
                if (cmd_valid) begin
                    unique case (cmd_e'(cmd_op))
                        OP_NOP: ;
                        OP_BEGIN: begin
                            if (depth_q < MAX_D) begin
                                state_d = S_EMIT_BEGIN;
                                depth_d = depth_q + ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_END: begin
                            if (depth_q != ZERO) begin
                                state_d = S_EMIT_END;
                                depth_d = depth_q - ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CLOSE: begin
                            if (depth_q != ZERO) begin
                                state_d = S_FLUSH;
                                depth_d = depth_q - ONE;
                            end
                        end
                    endcase
                end
            end
            S_EMIT_BEGIN, S_EMIT_END: begin
                if (last_q) begin
                    state_d = S_EMIT_SP;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_EMIT_SP: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
            S_FLUSH: begin
                if (last_q) begin
                    idx_d = 3'd0;
                    if (depth_q != ZERO)
                        depth_d = depth_q - ONE;
                    else
                        state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    block_token_rom u_rom (
        .tok_i   (state_token(state_d)),
        .idx_i   (idx_d),
        .upper_i (UPPER),
        .char_o  (rom_char),
        .last_o  (rom_last)
    );

    // state, counters and registered character outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            depth_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            out_q   <= CH_NUL;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            last_q  <= rom_last;
            out_q   <= (state_d != S_IDLE) ? rom_char : CH_NUL;
            valid_q <= (state_d != S_IDLE);
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign balanced  = (state_q == S_IDLE) && (depth_q == ZERO);
    assign out       = out_q;
    assign out_valid = valid_q;
    assign depth     = depth_q;
    assign err       = err_q;

endmodule

// File: tb/tb_block_emitter.sv
// tb_block_emitter: random and directed commands checked against a
// string-level model of the token stream, depth and error flag.
module tb_block_emitter;

    localparam int MAXD = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_ready;
    logic [7:0] out;
    logic       out_valid;
    logic [3:0] depth;
    logic       balanced;
    logic       err;

    logic       s_valid = 1'b0;
    logic [1:0] s_op = 2'b00;
    logic       s_ready;
    logic [7:0] s_out;
    logic       s_ov;
    logic [1:0] s_depth;
    logic       s_bal;
    logic       s_err;

    int n_cmp = 0;
    int n_bad = 0;
    int m_depth = 0;
    bit m_err = 1'b0;

    block_emitter #(.MAX_DEPTH(15), .DEPTH_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .out(out), .out_valid(out_valid),
        .depth(depth), .balanced(balanced), .err(err)
    );

    block_emitter #(.MAX_DEPTH(2), .DEPTH_W(2)) dut_small (
        .clk(clk), .reset(reset), .cmd_valid(s_valid), .cmd_op(s_op),
        .cmd_ready(s_ready), .out(s_out), .out_valid(s_ov),
        .depth(s_depth), .balanced(s_bal), .err(s_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef BLOCK_EMITTER_UPPER_EN
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
        return c;
    endfunction

    task automatic check_idle(input string name);
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 8'h00 || cmd_ready !== 1'b1 ||
            depth !== 4'(m_depth) || err !== m_err ||
            balanced !== (m_depth == 0)) begin
            n_bad++;
            $display("FAIL %s idle: got ov=%b out=%h rdy=%b d=%0d err=%b bal=%b want ov=0 out=00 rdy=1 d=%0d err=%b bal=%b",
                     name, out_valid, out, cmd_ready, depth, err, balanced,
                     m_depth, m_err, m_depth == 0);
        end
    endtask

    task automatic apply_reset();
        #2 reset = 1'b0;
        cmd_valid = 1'b0;
        m_depth = 0;
        m_err = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input bit junk);
        string s;
        logic [7:0] exp[$];
        int d0;
        int dexp;
        bit ok;
        s = "";
        d0 = m_depth;
        case (op)
            2'd1: if (m_depth < MAXD) begin m_depth++; s = "begin "; end
                  else m_err = 1'b1;
            2'd2: if (m_depth > 0) begin m_depth--; s = "end "; end
                  else m_err = 1'b1;
            2'd3: begin
                for (int i = 0; i < d0; i++) s = {s, "end "};
                m_depth = 0;
            end
            default: ;
        endcase
        exp = {};
        for (int i = 0; i < s.len(); i++) exp.push_back(fold(s[i]));
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL wait_ready: got rdy=%b want 1", cmd_ready);
        end
        cmd_op = op;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        for (int k = 0; k < exp.size(); k++) begin
            if (junk && k < exp.size() - 1) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = 2'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            dexp = (op == 2'd3) ? d0 - 1 - k / 4 : m_depth;
            n_cmp++;
            if (out_valid !== 1'b1 || out !== exp[k] ||
                depth !== 4'(dexp) || balanced !== 1'b0 ||
                cmd_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stream op=%0d k=%0d: got ov=%b out=%h d=%0d bal=%b rdy=%b want ov=1 out=%h d=%0d bal=0 rdy=0",
                         op, k, out_valid, out, depth, balanced, cmd_ready,
                         exp[k], dexp);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check_idle("after_cmd");
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("in_reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");
    endtask

    task automatic test_begin_end();
        apply_reset();
        run_cmd(2'd1, 1'b0);
        run_cmd(2'd2, 1'b0);
        run_cmd(2'd0, 1'b0);
    endtask

    task automatic test_underflow();
        apply_reset();
        run_cmd(2'd2, 1'b0);
        run_cmd(2'd1, 1'b0);
        run_cmd(2'd2, 1'b0);
        run_cmd(2'd0, 1'b0);
    endtask

    task automatic test_close_all();
        apply_reset();
        repeat (3) run_cmd(2'd1, 1'b0);
        run_cmd(2'd3, 1'b0);
        run_cmd(2'd3, 1'b0);
    endtask

    task automatic test_max_depth();
        apply_reset();
        repeat (MAXD + 1) run_cmd(2'd1, 1'b1);
        run_cmd(2'd3, 1'b1);
    endtask

    task automatic test_reset_midtoken();
        apply_reset();
        cmd_op = 2'd1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (out !== fold(8'h67) || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL third_char: got ov=%b out=%h want ov=1 out=%h",
                     out_valid, out, fold(8'h67));
        end
        reset = 1'b0;
        m_depth = 0;
        m_err = 1'b0;
        #1;
        check_idle("async_reset");
        @(posedge clk);
        #3 reset = 1'b1;
        run_cmd(2'd1, 1'b0);
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_small_max();
        int cnt;
        bit ok;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            ok = 1'b0;
            for (int w = 0; w < 50; w++) begin
                if (s_ready === 1'b1) begin ok = 1'b1; break; end
                @(posedge clk); #1;
            end
            s_op = 2'd1;
            s_valid = 1'b1;
            @(posedge clk); #1;
            s_valid = 1'b0;
            cnt = 0;
            for (int j = 0; j < 8; j++) begin
                if (s_ov === 1'b1) cnt++;
                @(posedge clk); #1;
            end
            n_cmp++;
            if (!ok || cnt != ((i < 2) ? 6 : 0)) begin
                n_bad++;
                $display("FAIL small_begin%0d: got chars=%0d ready_ok=%b want chars=%0d",
                         i, cnt, ok, (i < 2) ? 6 : 0);
            end
        end
        n_cmp++;
        if (s_depth !== 2'd2 || s_err !== 1'b1 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL small_final: got d=%0d err=%b rdy=%b want d=2 err=1 rdy=1",
                     s_depth, s_err, s_ready);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_begin_end();
        test_underflow();
        test_close_all();
        test_max_depth();
        test_reset_midtoken();
        test_random();
        test_small_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
